// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared widths, FSM states and op codes for the iterative multiply/divide unit
package multdiv_pkg;
    localparam int WIDTH = 32;
    localparam int CNT_W = 6;
    localparam int ITER_LAST = 31;
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    typedef enum logic {OP_MUL, OP_DIV} op_t;
endpackage

// File: rtl/multdiv_adder.sv
// multdiv_adder: 32-bit carry-select adder shared by every multiply/divide step
module multdiv_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [16:0] lo, hi0, hi1;
    assign lo  = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, cin};
    assign hi0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
    assign hi1 = hi0 + 17'd1;
    assign {cout, sum} = {lo[16] ? hi1 : hi0, lo[15:0]};
endmodule

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequencing FSM, iteration counter and start/abort decode
module multdiv_ctrl
    import multdiv_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic load,
    output logic iterate,
    output logic fix,
    output logic done
);
    state_t state, state_n;
    logic [CNT_W-1:0] count, count_n;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
        end
    end
    always_comb begin
        state_n = state;
        count_n = count;
        load    = 1'b0;
        iterate = 1'b0;
        fix     = 1'b0;
        done    = state == DONE;
        if (start) begin
            load    = 1'b1;
            state_n = RUN;
            count_n = '0;
        end else begin
            unique case (state)
                RUN: begin
                    iterate = 1'b1;
                    count_n = count + 1'b1;
                    state_n = count == CNT_W'(ITER_LAST) ? FIX : RUN;
                end
                FIX: begin
                    fix     = 1'b1;
                    state_n = DONE;
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: rtl/iterative_multdiv.sv
// iterative_multdiv: signed 32-bit Booth multiply / restoring divide through one shared adder
module iterative_multdiv
    import multdiv_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    logic load, iterate, fix;
    logic [WIDTH-1:0] acc, q, m, shr, add_a, add_b, sum;
    logic q_1, neg, dz, add_cin, cout, mul_sign;
    logic [1:0] booth;
    logic [WIDTH:0] mul_x, prod_hi;
    op_t op;
    multdiv_ctrl u_ctrl (
        .clock   (clock),
        .reset   (reset),
        .start   (ctrl_MULT | ctrl_DIV),
        .load    (load),
        .iterate (iterate),
        .fix     (fix),
        .done    (data_resultRDY)
    );
    multdiv_adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (sum),
        .cout (cout)
    );
    assign booth = {q[0], q_1};
    assign shr   = {acc[WIDTH-2:0], q[WIDTH-1]};
    // A negative divisor is added directly: R + B carries out exactly when R >= |B|
    assign add_a   = load ? ~data_operandA : fix ? ~q : op == OP_MUL ? acc : shr;
    assign add_b   = (load | fix) ? '0 : op == OP_MUL ? (booth == 2'b10 ? ~m : m) : (m[WIDTH-1] ? m : ~m);
    assign add_cin = (load | fix) ? 1'b1 : op == OP_MUL ? booth == 2'b10 : ~m[WIDTH-1];
    // Recover the 33rd bit of acc +/- M from signed overflow so M = -2^31 stays exact
    assign mul_sign = sum[WIDTH-1] ^ ((acc[WIDTH-1] == add_b[WIDTH-1]) & (sum[WIDTH-1] != acc[WIDTH-1]));
    assign mul_x    = (q[0] ^ q_1) ? {mul_sign, sum} : {acc[WIDTH-1], acc};
    assign prod_hi  = {acc, q[WIDTH-1]};
    always_ff @(posedge clock) begin
        if (reset) begin
            acc            <= '0;
            q              <= '0;
            q_1            <= 1'b0;
            m              <= '0;
            op             <= OP_MUL;
            neg            <= 1'b0;
            dz             <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (load) begin
            op  <= ctrl_MULT ? OP_MUL : OP_DIV;
            acc <= '0;
            q_1 <= 1'b0;
            q   <= ctrl_MULT ? data_operandB : (data_operandA[WIDTH-1] ? sum : data_operandA);
            m   <= ctrl_MULT ? data_operandA : data_operandB;
            neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz  <= data_operandB == '0;
        end else if (iterate) begin
            if (op == OP_MUL) begin
                {acc, q, q_1} <= {mul_x, q};
            end else begin
                acc <= cout ? sum : shr;
                q   <= {q[WIDTH-2:0], cout};
            end
        end else if (fix) begin
            if (op == OP_MUL) begin
                data_result    <= q;
                data_exception <= ~(&prod_hi | ~|prod_hi);
            end else begin
                data_result    <= dz ? '0 : neg ? sum : q;
                data_exception <= dz | (~neg & q[WIDTH-1]);
            end
        end
    end
endmodule

// File: tb/tb_iterative_multdiv.sv
// tb_iterative_multdiv: directed vectors for latency, results, exceptions, abort and reset
module tb_iterative_multdiv;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    int checks = 0;
    int errors = 0;
    int seen;
    iterative_multdiv dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic pulse(input logic mul, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT = mul;
        ctrl_DIV = !mul;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
    endtask
    task automatic wait_rdy(input string tag, input logic [31:0] exp_res, input logic exp_exc);
        int n = 0;
        while (!data_resultRDY && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        check({tag, " latency"}, n, 33);
        check({tag, " result"}, data_result, exp_res);
        check({tag, " exception"}, {31'd0, data_exception}, {31'd0, exp_exc});
        @(posedge clock);
        #1;
        check({tag, " rdy width"}, {31'd0, data_resultRDY}, 32'd0);
    endtask
    task automatic op(input string tag, input logic mul, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_res, input logic exp_exc);
        pulse(mul, a, b);
        wait_rdy(tag, exp_res, exp_exc);
    endtask
    task automatic no_rdy(input string tag);
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) seen++;
        end
        check(tag, seen, 0);
    endtask
    initial begin
        ctrl_MULT = 1'b1;
        data_operandA = 32'd6;
        data_operandB = 32'd7;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        ctrl_MULT = 1'b0;
        check("reset result", data_result, 32'd0);
        check("reset exception", {31'd0, data_exception}, 32'd0);
        check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        no_rdy("reset beats mult");
        op("mul 6x7", 1'b1, 32'd6, 32'd7, 32'd42, 1'b0);
        op("mul -3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0);
        op("mul -7x-6", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'd42, 1'b0);
        op("mul 2^16x2^16", 1'b1, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1);
        op("mul min x min", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1);
        op("mul min x 1", 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
        op("div 100/-7", 1'b0, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
        op("div -100/7", 1'b0, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0);
        op("div 7/100", 1'b0, 32'd7, 32'd100, 32'd0, 1'b0);
        op("div 5/0", 1'b0, 32'd5, 32'd0, 32'd0, 1'b1);
        op("div min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        op("div min/1", 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
        pulse(1'b1, 32'd9, 32'd9);
        repeat (9) @(posedge clock);
        pulse(1'b0, 32'd20, 32'd3);
        wait_rdy("abort div 20/3", 32'd6, 1'b0);
        pulse(1'b1, 32'd3, 32'd4);
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midop reset result", data_result, 32'd0);
        check("midop reset exception", {31'd0, data_exception}, 32'd0);
        check("midop reset rdy", {31'd0, data_resultRDY}, 32'd0);
        no_rdy("midop reset no rdy");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
